cv32e40p_apu_responder: RTL and testbench
=========================================

CV32E40P_APU_RESPONDER -- requirements
Module: cv32e40p_apu_responder

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
  APU_NARGS_CPU, 3, number of 32-bit operands
  APU_WOP_CPU, 6, opcode width
  APU_NDSFLAGS_CPU, 15, downstream flag width
  APU_NUSFLAGS_CPU, 5, upstream flag width
  LAT, 2, pipelined-op latency in cycles (legal 1..4)
REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
  clk  in  1  clock; only clock, all state on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  apu_req_i  in  1  request from core
  apu_gnt_o  out  1  grant; request accepted this cycle when req & gnt
  apu_operands_i  in  APU_NARGS_CPU*32  operands a=[31:0], b=[63:32], c=[95:64]
  apu_op_i  in  APU_WOP_CPU  opcode
  apu_flags_i  in  APU_NDSFLAGS_CPU  downstream flags, accepted and ignored
  apu_rvalid_o  out  1  single-cycle result-valid pulse
  apu_result_o  out  32  result, meaningful only with rvalid
  apu_rflags_o  out  APU_NUSFLAGS_CPU  status flags, meaningful only with rvalid
  busy_o  out  1  any operation in flight

Function
REQ-003 Opcodes SHALL be: 0 ADD a+b; 1 SUB a-b; 2 MIN signed; 3 MAX signed; 4 MAC a*b+c (low 32 bits, wrap); 5 DIVU a/b unsigned; any other value yields result 0 and flags 0 with pipelined timing.
REQ-004 Ops 0-4 and unknown ops SHALL be pipelined: granted in cycle N, apu_rvalid_o high exactly in cycle N+LAT, one new accept per cycle, results in grant order.
REQ-005 Pipelined ops SHALL compute in the grant cycle from the operands sampled then; later operand changes SHALL not affect the result.
REQ-006 DIVU SHALL use a radix-2 iterative FSM with states IDLE, ITER, DONE: IDLE->ITER on grant; ITER runs exactly 32 cycles then ->DONE; DONE asserts rvalid for one cycle then ->IDLE; grant in cycle N gives rvalid in cycle N+33.
REQ-007 DIVU with b==0 SHALL go IDLE->DONE directly (rvalid in N+1), result 32'hFFFF_FFFF, rflags[3] (DZ) set.
REQ-008 apu_gnt_o SHALL be combinational: req & (FSM==IDLE) & (op!=DIVU | no pipeline stage valid, including the stage driving rvalid this cycle).
REQ-009 While FSM is not IDLE, apu_gnt_o SHALL be 0 for every opcode.
REQ-010 Pipeline and divider SHALL never assert rvalid in the same cycle (guaranteed by REQ-008/009).
REQ-011 rflags[2] (OF) SHALL be set on signed overflow of ADD/SUB; all other flag bits SHALL be 0 unless stated; flags SHALL be 0 whenever rvalid is 0.
REQ-012 apu_result_o SHALL be 0 when apu_rvalid_o is 0.
REQ-013 busy_o SHALL be high when any pipeline stage is valid or FSM is not IDLE.
REQ-014 Requests with apu_req_i low SHALL not alter any state; there SHALL be no backpressure on rvalid.

Reset
REQ-015 On rst_n low, asynchronously: all pipeline valids cleared, FSM->IDLE, apu_rvalid_o=0, apu_result_o=0, apu_rflags_o=0, busy_o=0; apu_gnt_o follows REQ-008 from the reset state.
REQ-016 Reset during an in-flight operation (pipelined or DIVU) SHALL discard it; no rvalid for it after release.

Verification
REQ-017 LAT=2, ADD a=32'h7FFF_FFFF b=1 granted cycle 10 -> rvalid cycle 12, result 32'h8000_0000, rflags=5'b00100.
REQ-018 Back-to-back grants cycles 0,1,2: SUB 5-7, MIN(-3,2), MAC(3,4,5) -> rvalid cycles 2,3,4 with 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd17.
REQ-019 DIVU 100/7 granted cycle 0 -> gnt=0 for all req cycles 1..33, rvalid cycle 33 result 14, flags 0; DIVU 9/0 -> rvalid next cycle, result 32'hFFFF_FFFF, rflags=5'b01000.
REQ-020 ADD granted cycle 0, DIVU requested cycles 1..2 (LAT=2) -> gnt=0 until pipeline empty, DIVU granted cycle 3.
REQ-021 rst_n pulsed low at cycle 15 of a DIVU -> outputs 0 immediately, busy_o=0, no rvalid afterwards; next ADD after release completes normally.

Source files
------------

// File: rtl/cv32e40p_apu_responder_if.sv
// APU request/response bundle between the core (master) and the responder (slave).
// The members keep the core-side signal names so waveforms line up with the core.
interface cv32e40p_apu_responder_if #(
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NDSFLAGS_CPU = 15,
  parameter int APU_NUSFLAGS_CPU = 5
);
  logic                          apu_req_i;
  logic                          apu_gnt_o;
  logic [APU_NARGS_CPU*32-1:0]   apu_operands_i;
  logic [APU_WOP_CPU-1:0]        apu_op_i;
  logic [APU_NDSFLAGS_CPU-1:0]   apu_flags_i;
  logic                          apu_rvalid_o;
  logic [31:0]                   apu_result_o;
  logic [APU_NUSFLAGS_CPU-1:0]   apu_rflags_o;

  modport master (
    output apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
    input  apu_gnt_o, apu_rvalid_o, apu_result_o, apu_rflags_o
  );

  modport slave (
    input  apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
    output apu_gnt_o, apu_rvalid_o, apu_result_o, apu_rflags_o
  );
endinterface

// File: rtl/cv32e40p_apu_responder.sv
// APU responder: fixed-latency pipeline for ALU/MAC ops plus a radix-2 iterative
// unsigned divider. Both paths share one response port and never collide.
module cv32e40p_apu_responder #(
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NDSFLAGS_CPU = 15,
  parameter int APU_NUSFLAGS_CPU = 5,
  parameter int LAT              = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cv32e40p_apu_responder_if.slave  apu,
  output logic                     busy_o
);

  localparam logic [APU_WOP_CPU-1:0] OP_ADD  = APU_WOP_CPU'(0);
  localparam logic [APU_WOP_CPU-1:0] OP_SUB  = APU_WOP_CPU'(1);
  localparam logic [APU_WOP_CPU-1:0] OP_MIN  = APU_WOP_CPU'(2);
  localparam logic [APU_WOP_CPU-1:0] OP_MAX  = APU_WOP_CPU'(3);
  localparam logic [APU_WOP_CPU-1:0] OP_MAC  = APU_WOP_CPU'(4);
  localparam logic [APU_WOP_CPU-1:0] OP_DIVU = APU_WOP_CPU'(5);

  localparam int FLG_OF = 2;
  localparam int FLG_DZ = 3;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} div_state_e;

  function automatic logic add_ovf(input logic signed [31:0] x, y, s);
    return (x[31] == y[31]) && (s[31] != x[31]);
  endfunction

  function automatic logic sub_ovf(input logic signed [31:0] x, y, s);
    return (x[31] != y[31]) && (s[31] != x[31]);
  endfunction

  logic signed [31:0] a_s, b_s, c_s;
  logic signed [31:0] sum_c, dif_c, mac_c;
  logic [31:0]        res_c;
  logic [APU_NUSFLAGS_CPU-1:0] flg_c;
  logic is_divu, b_zero;
  logic gnt, acc_pipe, acc_div;

  logic [LAT-1:0]              vld_p;
  logic [31:0]                 res_p [LAT];
  logic [APU_NUSFLAGS_CPU-1:0] flg_p [LAT];

  div_state_e  state, state_nxt;
  logic        div_idle, div_iter, div_vld;
  logic [4:0]  cnt;
  logic [31:0] quo, rem, dvs;
  logic        dz;
  logic [32:0] rem_sh, sub;
  logic [APU_NUSFLAGS_CPU-1:0] div_flg;

  logic unused_flags;
  assign unused_flags = ^apu.apu_flags_i;

  assign a_s = apu.apu_operands_i[31:0];
  assign b_s = apu.apu_operands_i[63:32];
  assign c_s = apu.apu_operands_i[95:64];

  assign is_divu = (apu.apu_op_i == OP_DIVU);
  assign b_zero  = (b_s == 32'sd0);

  // Divide may only start once the pipeline is fully drained, so the two
  // result sources can never drive rvalid in the same cycle.
  assign gnt      = apu.apu_req_i & div_idle & (~is_divu | ~(|vld_p));
  assign acc_pipe = gnt & ~is_divu;
  assign acc_div  = gnt & is_divu;

  assign sum_c = a_s + b_s;
  assign dif_c = a_s - b_s;
  assign mac_c = a_s * b_s + c_s;

  always_comb begin
    res_c = '0;
    flg_c = '0;
    case (apu.apu_op_i)
      OP_ADD: begin
        res_c         = sum_c;
        flg_c[FLG_OF] = add_ovf(a_s, b_s, sum_c);
      end
      OP_SUB: begin
        res_c         = dif_c;
        flg_c[FLG_OF] = sub_ovf(a_s, b_s, dif_c);
      end
      OP_MIN:  res_c = (a_s < b_s) ? a_s : b_s;
      OP_MAX:  res_c = (a_s > b_s) ? a_s : b_s;
      OP_MAC:  res_c = mac_c;
      default: res_c = '0;
    endcase
  end

  // Stage p0 captures the result in the grant cycle; later stages just delay it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= acc_pipe;
      for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (acc_pipe) begin
      res_p[0] <= res_c;
      flg_p[0] <= flg_c;
    end
    for (int i = 1; i < LAT; i++) begin
      res_p[i] <= res_p[i-1];
      flg_p[i] <= flg_p[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (acc_div) state_nxt = b_zero ? S_DONE : S_ITER;
      S_ITER:  if (cnt == 5'd31) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    div_idle = (state == S_IDLE);
    div_iter = (state == S_ITER);
    div_vld  = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (acc_div)  cnt <= '0;
    else if (div_iter) cnt <= cnt + 5'd1;
  end

  // Restoring division: shift the next dividend bit into the remainder and
  // keep the subtraction only when it does not go negative.
  assign rem_sh = {rem, quo[31]};
  assign sub    = rem_sh - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (acc_div) begin
      quo <= b_zero ? 32'hFFFF_FFFF : a_s;
      rem <= '0;
      dvs <= b_s;
      dz  <= b_zero;
    end else if (div_iter) begin
      quo <= {quo[30:0], ~sub[32]};
      rem <= sub[32] ? rem_sh[31:0] : sub[31:0];
    end
  end

  always_comb begin
    div_flg         = '0;
    div_flg[FLG_DZ] = dz;
  end

  // Result and flags are forced to zero whenever no source is valid.
  always_comb begin
    apu.apu_gnt_o    = gnt;
    apu.apu_rvalid_o = vld_p[LAT-1] | div_vld;
    apu.apu_result_o = '0;
    apu.apu_rflags_o = '0;
    if (vld_p[LAT-1]) begin
      apu.apu_result_o = res_p[LAT-1];
      apu.apu_rflags_o = flg_p[LAT-1];
    end else if (div_vld) begin
      apu.apu_result_o = quo;
      apu.apu_rflags_o = div_flg;
    end
  end

  assign busy_o = (|vld_p) | ~div_idle;

endmodule

// File: tb/tb_cv32e40p_apu_responder.sv
// Bench for cv32e40p_apu_responder: vector table, divider and reset sequences,
// and a random mix, all checked cycle by cycle against a scoreboard queue.
module tb_cv32e40p_apu_responder;

  localparam int LAT = 2;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b, c;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] res;
    logic [4:0]  flg;
    bit          is_div;
  } exp_t;

  logic clk;
  logic rst_n;
  logic busy;
  int   cyc;
  int   n_vec;
  int   n_mis;
  exp_t sb[$];

  cv32e40p_apu_responder_if #(
    .APU_NARGS_CPU(3), .APU_WOP_CPU(6), .APU_NDSFLAGS_CPU(15), .APU_NUSFLAGS_CPU(5)
  ) apu ();

  cv32e40p_apu_responder #(
    .APU_NARGS_CPU(3), .APU_WOP_CPU(6), .APU_NDSFLAGS_CPU(15), .APU_NUSFLAGS_CPU(5),
    .LAT(LAT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .apu    (apu),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void model(input logic [5:0] op, input logic [31:0] a, b, c,
                                output logic [31:0] r, output logic [4:0] f, output int lat);
    longint s;
    r = '0; f = '0; lat = LAT;
    case (op)
      6'd0: begin
        r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        f[2] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'd1: begin
        r = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        f[2] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'd2: r = ($signed(a) < $signed(b)) ? a : b;
      6'd3: r = ($signed(a) > $signed(b)) ? a : b;
      6'd4: r = a * b + c;
      6'd5: begin
        if (b == 32'd0) begin r = 32'hFFFF_FFFF; f = 5'b01000; lat = 1; end
        else begin r = a / b; lat = 33; end
      end
      default: r = '0;
    endcase
  endfunction

  // One clock cycle: drive, check grant/busy/response, record any accept.
  task automatic drive_cycle(input bit req, input logic [5:0] op, input logic [31:0] a, b, c,
                             input logic [31:0] er, input logic [4:0] ef, input int lat,
                             output bit granted);
    bit any_div, any_pipe, exp_gnt;
    apu.apu_req_i      = req;
    apu.apu_op_i       = op;
    apu.apu_operands_i = {c, b, a};
    apu.apu_flags_i    = 15'($urandom);
    #1;
    any_div  = 1'b0;
    any_pipe = 1'b0;
    foreach (sb[i]) begin
      if (sb[i].is_div) any_div = 1'b1;
      else              any_pipe = 1'b1;
    end
    exp_gnt = req && !any_div && (op != 6'd5 || !any_pipe);
    chk("gnt", {31'b0, apu.apu_gnt_o}, {31'b0, exp_gnt});
    chk("busy", {31'b0, busy}, {31'b0, sb.size() != 0});
    if (sb.size() != 0 && sb[0].due == cyc) begin
      chk("rvalid", {31'b0, apu.apu_rvalid_o}, 32'd1);
      chk("result", apu.apu_result_o, sb[0].res);
      chk("rflags", {27'b0, apu.apu_rflags_o}, {27'b0, sb[0].flg});
      void'(sb.pop_front());
    end else begin
      chk("rvalid_idle", {31'b0, apu.apu_rvalid_o}, 32'd0);
      chk("result_idle", apu.apu_result_o, 32'd0);
      chk("rflags_idle", {27'b0, apu.apu_rflags_o}, 32'd0);
    end
    granted = req && (apu.apu_gnt_o === 1'b1);
    if (granted) sb.push_back('{cyc + lat, er, ef, op == 6'd5});
    @(negedge clk);
    cyc++;
  endtask

  task automatic issue(input bit req, input logic [5:0] op, input logic [31:0] a, b, c,
                       output bit granted);
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
    model(op, a, b, c, r, f, lat);
    drive_cycle(req, op, a, b, c, r, f, lat, granted);
  endtask

  task automatic idle(input int n);
    bit g;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 6'($urandom), $urandom, $urandom, $urandom, 0, 0, 0, g);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) idle(1);
    chk("drain", sb.size(), 0);
    idle(2);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid", {31'b0, apu.apu_rvalid_o}, 32'd0);
    chk("rst_result", apu.apu_result_o, 32'd0);
    chk("rst_rflags", {27'b0, apu.apu_rflags_o}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
  endtask

  vec_t tbl[16];
  logic [31:0] dv_a[6];
  logic [31:0] dv_b[6];

  initial begin
    bit g;
    int t0, lat;
    logic [31:0] r, ra, rb;
    logic [4:0] f;
    logic [5:0] op;

    tbl[0]  = '{6'd0, 32'h7FFF_FFFF, 32'd1,         32'd0,  32'h8000_0000, 5'b00100};
    tbl[1]  = '{6'd1, 32'd5,         32'd7,         32'd0,  32'hFFFF_FFFE, 5'b00000};
    tbl[2]  = '{6'd2, 32'hFFFF_FFFD, 32'd2,         32'd0,  32'hFFFF_FFFD, 5'b00000};
    tbl[3]  = '{6'd4, 32'd3,         32'd4,         32'd5,  32'd17,        5'b00000};
    tbl[4]  = '{6'd0, 32'd1,         32'd2,         32'd9,  32'd3,         5'b00000};
    tbl[5]  = '{6'd1, 32'h8000_0000, 32'd1,         32'd0,  32'h7FFF_FFFF, 5'b00100};
    tbl[6]  = '{6'd1, 32'd0,         32'h8000_0000, 32'd0,  32'h8000_0000, 5'b00100};
    tbl[7]  = '{6'd3, 32'hFFFF_FFFF, 32'd1,         32'd0,  32'd1,         5'b00000};
    tbl[8]  = '{6'd3, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0,  32'h7FFF_FFFF, 5'b00000};
    tbl[9]  = '{6'd2, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0,  32'h8000_0000, 5'b00000};
    tbl[10] = '{6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,  32'hFFFF_FFFE, 5'b00000};
    tbl[11] = '{6'd0, 32'h8000_0000, 32'h8000_0000, 32'd0,  32'd0,         5'b00100};
    tbl[12] = '{6'd4, 32'hFFFF_FFFF, 32'd2,         32'd10, 32'd8,         5'b00000};
    tbl[13] = '{6'd4, 32'h0001_0000, 32'h0001_0000, 32'd1,  32'd1,         5'b00000};
    tbl[14] = '{6'd7, 32'd5,         32'd6,         32'd7,  32'd0,         5'b00000};
    tbl[15] = '{6'd63, 32'hFFFF_FFFF, 32'd1,        32'd1,  32'd0,         5'b00000};

    dv_a = '{32'd100, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,  32'h8000_0000};
    dv_b = '{32'd7,   32'd0, 32'd1,         32'hFFFF_FFFF, 32'd10, 32'd3};

    n_vec = 0; n_mis = 0; cyc = 0;
    rst_n = 1'b0;
    apu.apu_req_i = 1'b1; apu.apu_op_i = 6'd0; apu.apu_operands_i = '0; apu.apu_flags_i = '0;
    @(negedge clk);
    #1;
    chk("rst_rvalid", {31'b0, apu.apu_rvalid_o}, 32'd0);
    chk("rst_result", apu.apu_result_o, 32'd0);
    chk("rst_rflags", {27'b0, apu.apu_rflags_o}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_gnt", {31'b0, apu.apu_gnt_o}, 32'd1);
    apu.apu_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Back-to-back table vectors, then isolated ADD to confirm exact latency.
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].res, tbl[i].flg, LAT, g);
      chk("tbl_gnt", {31'b0, g}, 32'd1);
    end
    drain();
    drive_cycle(1'b1, 6'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h8000_0000, 5'b00100, LAT, g);
    drain();

    // Each divide holds its request through the whole operation; no re-grant.
    for (int i = 0; i < 6; i++) begin
      model(6'd5, dv_a[i], dv_b[i], 32'd0, r, f, lat);
      drive_cycle(1'b1, 6'd5, dv_a[i], dv_b[i], 32'd0, r, f, lat, g);
      chk("div_gnt", {31'b0, g}, 32'd1);
      for (int k = 0; k < lat; k++) issue(1'b1, 6'($urandom_range(0, 5)), dv_a[i], dv_b[i], 32'd0, g);
      drain();
    end

    // DIVU waits for the pipeline to empty behind an ADD.
    issue(1'b1, 6'd0, 32'd4, 32'd5, 32'd0, g);
    t0 = cyc - 1;
    g = 1'b0;
    for (int k = 0; k < 10 && !g; k++) issue(1'b1, 6'd5, 32'd50, 32'd5, 32'd0, g);
    chk("divu_after_pipe", cyc - 1 - t0, 32'd3);
    drain();

    // Reset in the middle of a divide, then a normal ADD.
    issue(1'b1, 6'd5, 32'd1000, 32'd3, 32'd0, g);
    idle(14);
    reset_now();
    idle(40);
    issue(1'b1, 6'd0, 32'd2, 32'd3, 32'd0, g);
    drain();

    // Reset with a pipelined op in flight.
    issue(1'b1, 6'd1, 32'd9, 32'd4, 32'd0, g);
    reset_now();
    idle(5);

    // Random mix of requests, ops and operands.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 15))
        0, 1, 2:  op = 6'd0;
        3, 4, 5:  op = 6'd1;
        6, 7:     op = 6'd2;
        8, 9:     op = 6'd3;
        10, 11:   op = 6'd4;
        12:       op = 6'd5;
        13, 14:   op = 6'd0;
        default:  op = 6'($urandom_range(6, 63));
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      issue($urandom_range(0, 9) < 7, op, ra, rb, $urandom, g);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
